// File: rtl/me_pkg.sv
// Shared motion-estimation definitions: field widths and the packed result record layout.
package me_pkg;
  localparam int SAD_W     = 14;
  localparam int MV_W      = 4;
  localparam int BLK_IDX_W = 9;
  localparam int REC_W     = 40;

  localparam int SAD_LSB  = 0;
  localparam int MVX_LSB  = SAD_LSB + SAD_W;
  localparam int MVY_LSB  = MVX_LSB + MV_W;
  localparam int BLKX_LSB = MVY_LSB + MV_W;
  localparam int BLKY_LSB = BLKX_LSB + BLK_IDX_W;

  function automatic logic [REC_W-1:0] pack_rec(
    input logic [BLK_IDX_W-1:0] blk_y,
    input logic [BLK_IDX_W-1:0] blk_x,
    input logic [MV_W-1:0]      mv_y,
    input logic [MV_W-1:0]      mv_x,
    input logic [SAD_W-1:0]     sad
  );
    return {blk_y, blk_x, mv_y, mv_x, sad};
  endfunction
endpackage

// File: rtl/mv_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
module mv_fifo #(
  parameter int DATA_W = 40,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot being written, so a full FIFO still accepts a push.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mv_collector.sv
// Tags SAD-core results with their raster block position and queues them for a ready/valid consumer.
module mv_collector
  import me_pkg::*;
#(
  parameter int BLK_COLS   = 480,
  parameter int BLK_ROWS   = 270,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             sad_en,
  input  logic [SAD_W-1:0] sad_min,
  input  logic [MV_W-1:0]  motion_vec_x_min,
  input  logic [MV_W-1:0]  motion_vec_y_min,
  output logic             mv_valid,
  input  logic             mv_ready,
  output logic [REC_W-1:0] mv_data,
  output logic             frame_done,
  output logic             overflow
);
  localparam logic [BLK_IDX_W-1:0] LAST_X = BLK_IDX_W'(BLK_COLS - 1);
  localparam logic [BLK_IDX_W-1:0] LAST_Y = BLK_IDX_W'(BLK_ROWS - 1);

  logic [BLK_IDX_W-1:0] blk_x, blk_y;
  logic [BLK_IDX_W-1:0] tag_x, tag_y, nxt_x, nxt_y;
  logic                 last_blk, push, pop, full, empty;
  logic [REC_W-1:0]     rec;

  // A frame_start arriving with a result restarts numbering at that very result.
  always_comb begin
    tag_x    = frame_start ? '0 : blk_x;
    tag_y    = frame_start ? '0 : blk_y;
    last_blk = (tag_x == LAST_X) && (tag_y == LAST_Y);
    nxt_x    = tag_x + 1'b1;
    nxt_y    = tag_y;
    if (tag_x == LAST_X) begin
      nxt_x = '0;
      nxt_y = (tag_y == LAST_Y) ? '0 : tag_y + 1'b1;
    end
  end

  assign rec      = pack_rec(tag_y, tag_x, motion_vec_y_min, motion_vec_x_min, sad_min);
  assign mv_valid = !empty;
  assign pop      = mv_valid && mv_ready;
  assign push     = sad_en && (!full || pop);

  mv_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rec),
    .pop   (pop),
    .dout  (mv_data),
    .full  (full),
    .empty (empty)
  );

  // Counters advance even on a dropped result so later tags stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_x      <= '0;
      blk_y      <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= push && last_blk;
      if (sad_en) begin
        blk_x <= nxt_x;
        blk_y <= nxt_y;
      end else if (frame_start) begin
        blk_x <= '0;
        blk_y <= '0;
      end
      if (sad_en && !push) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mv_collector.sv
// Randomised and directed bench for mv_collector against a queue-based reference model.
module tb_mv_collector;
  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int DEPTH = 8;
  localparam int NBLK  = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst, frame_start, sad_en, mv_ready;
  logic [13:0] sad_min;
  logic [3:0]  mvx, mvy;
  logic        mv_valid, frame_done, overflow;
  logic [39:0] mv_data;

  int tests = 0;
  int fails = 0;

  logic [39:0] q[$];
  int          pos;
  bit          ov_m, fd_m;

  always #5 clk = ~clk;

  mv_collector #(
    .BLK_COLS   (COLS),
    .BLK_ROWS   (ROWS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .frame_start      (frame_start),
    .sad_en           (sad_en),
    .sad_min          (sad_min),
    .motion_vec_x_min (mvx),
    .motion_vec_y_min (mvy),
    .mv_valid         (mv_valid),
    .mv_ready         (mv_ready),
    .mv_data          (mv_data),
    .frame_done       (frame_done),
    .overflow         (overflow)
  );

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] mk_rec(input int idx, input logic [3:0] my, input logic [3:0] mx,
                                         input logic [13:0] s);
    logic [8:0] by, bx;
    by = 9'(idx / COLS);
    bx = 9'(idx % COLS);
    return {by, bx, my, mx, s};
  endfunction

  // One clock: drive on the falling edge, update the model, check just after the rising edge.
  task automatic cycle(input bit r, input bit fs, input bit en, input bit rdy,
                       input logic [13:0] s, input logic [3:0] mx, input logic [3:0] my);
    bit          popd;
    logic [39:0] exp_d;
    @(negedge clk);
    rst = r; frame_start = fs; sad_en = en; mv_ready = rdy;
    sad_min = s; mvx = mx; mvy = my;
    if (r) begin
      q.delete(); pos = 0; ov_m = 0; fd_m = 0;
    end else begin
      fd_m = 0;
      popd = (q.size() > 0) && rdy;
      if (popd) void'(q.pop_front());
      if (en) begin
        if (fs) pos = 0;
        if (q.size() < DEPTH) begin
          q.push_back(mk_rec(pos, my, mx, s));
          fd_m = (pos == NBLK - 1);
        end else begin
          ov_m = 1;
        end
        pos = (pos + 1) % NBLK;
      end else if (fs) begin
        pos = 0;
      end
    end
    @(posedge clk);
    #1;
    exp_d = (q.size() > 0) ? q[0] : 40'd0;
    check("mv_valid", {39'd0, mv_valid}, {39'd0, q.size() > 0});
    check("mv_data", mv_data, exp_d);
    check("overflow", {39'd0, overflow}, {39'd0, ov_m});
    check("frame_done", {39'd0, frame_done}, {39'd0, fd_m});
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 14'd0, 4'd0, 4'd0);
  endtask

  task automatic pulse(input bit rdy);
    cycle(0, 0, 1, rdy, 14'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 0, 0, rdy, 14'd0, 4'd0, 4'd0);
  endtask

  int fd_cnt, pops;

  initial begin
    rst = 1; frame_start = 0; sad_en = 0; mv_ready = 0;
    sad_min = '0; mvx = '0; mvy = '0;
    pos = 0; ov_m = 0; fd_m = 0;

    // Reset state and first-result latency
    do_reset();
    do_reset();
    cycle(0, 0, 1, 1, 14'h0123, 4'd5, 4'd9);
    check("first_rec", mv_data, 40'h0000254123);
    check("first_valid", {39'd0, mv_valid}, 40'd1);
    idle(1);

    // Full raster of 4x2 blocks plus wrap to the next frame
    do_reset();
    fd_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      pulse(1);
      if (frame_done) fd_cnt++;
    end
    check("wrap_tag", {22'd0, mv_data[39:22]}, 40'd0);
    idle(1);
    check("frame_done_count", 40'(fd_cnt), 40'd1);

    // Overflow on the ninth result, tags stay aligned after draining
    do_reset();
    for (int i = 0; i < 9; i++) pulse(0);
    check("ovf_set", {39'd0, overflow}, 40'd1);
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      if (mv_valid) pops++;
      idle(1);
    end
    check("ovf_stored", 40'(pops), 40'd8);
    pulse(0);
    check("ovf_next_tag", {22'd0, mv_data[39:22]}, {22'd0, 9'd0, 9'd1});
    cycle(0, 1, 0, 0, 14'd0, 4'd0, 4'd0);
    check("ovf_sticky_fs", {39'd0, overflow}, 40'd1);

    // Full FIFO accepts a push that coincides with a pop
    do_reset();
    for (int i = 0; i < 8; i++) pulse(0);
    pulse(1);
    check("full_pushpop_ovf", {39'd0, overflow}, 40'd0);
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      if (mv_valid) pops++;
      idle(1);
    end
    check("full_pushpop_occ", 40'(pops), 40'd8);

    // frame_start coincident with a result at blk_x=3, then frame_start alone
    do_reset();
    for (int i = 0; i < 3; i++) pulse(1);
    cycle(0, 1, 1, 1, 14'h0aa, 4'd1, 4'd2);
    check("fs_tag", {22'd0, mv_data[39:22]}, 40'd0);
    pulse(1);
    check("fs_next_tag", {22'd0, mv_data[39:22]}, {22'd0, 9'd0, 9'd1});
    pulse(1);
    cycle(0, 1, 0, 1, 14'd0, 4'd0, 4'd0);
    pulse(1);
    check("fs_alone_tag", {22'd0, mv_data[39:22]}, 40'd0);

    // Reset with entries queued
    do_reset();
    for (int i = 0; i < 5; i++) pulse(0);
    do_reset();
    check("rst_valid", {39'd0, mv_valid}, 40'd0);
    check("rst_ovf", {39'd0, overflow}, 40'd0);
    pulse(0);
    check("rst_tag", {22'd0, mv_data[39:22]}, 40'd0);

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 29) == 0),
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
            14'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
